// File: rtl/ins_mem_loader.sv
// Instruction memory loader: packs a host byte stream little-endian into words and writes them to BRAM port A.
// Latency: one WRITE cycle after the last byte of each word; load_done in the first RUN cycle.
// Backpressure: s_ready is high only in LOAD, so the stream stalls during WRITE, IDLE and RUN.
module ins_mem_loader #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int INS_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [INS_ADDR_WIDTH:0]   load_words,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      ins_we,
    output logic [INS_ADDR_WIDTH-1:0] ins_addr,
    output logic [INS_WIDTH-1:0]      ins_wdata,
    output logic                      core_hold,
    output logic                      busy,
    output logic                      load_done,
    output logic [INS_WIDTH-1:0]      checksum
);
    localparam int BYTES_PER_WORD = INS_WIDTH / 8;
    localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    // A session never writes more words than the memory holds, so the address cannot wrap.
    localparam logic [INS_ADDR_WIDTH:0] MAX_WORDS = {1'b1, {INS_ADDR_WIDTH{1'b0}}};
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

    state_t                      state_q, state_d;
    logic [INS_ADDR_WIDTH:0]     len_q, len_d;
    logic [BCW-1:0]              byte_cnt_q, byte_cnt_d;
    logic [INS_ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic [INS_ADDR_WIDTH:0]     word_cnt_inc;
    logic [INS_WIDTH-1:0]        asm_q, asm_d;
    logic [INS_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [INS_WIDTH-1:0]        wdata_q, wdata_d;
    logic [INS_WIDTH-1:0]        csum_q, csum_d;
    logic                        done_q, done_d;

    assign word_cnt_inc = word_cnt_q + 1'b1;

    assign ins_we    = (state_q == WRITE);
    assign ins_addr  = addr_q;
    assign ins_wdata = wdata_q;
    assign core_hold = (state_q != RUN);
    assign busy      = (state_q == LOAD) || (state_q == WRITE);
    assign load_done = done_q;
    assign checksum  = csum_q;

    // Next-state logic: session start, byte packing, word write and completion.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        csum_d     = csum_q;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                // RUN shares the IDLE start path so the core can be re-programmed.
                if (load_start) begin
                    len_d      = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    asm_d      = '0;
                    if (load_words == '0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    asm_d[8*byte_cnt_q +: 8] = s_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Capture the finished word so port A holds it after WRITE.
                        byte_cnt_d = '0;
                        addr_d     = word_cnt_q[INS_ADDR_WIDTH-1:0];
                        wdata_d    = asm_d;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                csum_d     = csum_q ^ wdata_q;
                word_cnt_d = word_cnt_inc;
                if (word_cnt_inc == len_q) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any session, BRAM keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader: directed loads with a write/checksum scoreboard checked by a monitor.
// Stimulus is driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The byte driver re-presents a byte until it is accepted, so stalls never drop data.
module tb_ins_mem_loader;
    localparam int AW = 8;
    localparam int IW = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_words;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ins_we;
    logic [AW-1:0] ins_addr;
    logic [IW-1:0] ins_wdata;
    logic          core_hold;
    logic          busy;
    logic          load_done;
    logic [IW-1:0] checksum;

    ins_mem_loader #(.INS_ADDR_WIDTH(AW), .INS_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_words(load_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ins_we(ins_we), .ins_addr(ins_addr), .ins_wdata(ins_wdata),
        .core_hold(core_hold), .busy(busy), .load_done(load_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    wr_t wq[$];
    logic [IW-1:0] cq[$];
    int we_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_acc_cyc = -1;
    int start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mkword(input int base);
        logic [IW-1:0] w;
        w = '0;
        for (int k = 0; k < IW/8; k++) w[8*k +: 8] = 8'(base + k);
        return w;
    endfunction

    task automatic exp_wr(input int a, input logic [IW-1:0] d);
        wr_t e;
        e.addr = a[AW-1:0];
        e.data = d;
        wq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every port A write and every load_done pulse.
    always @(negedge clk) begin
        if (ins_we === 1'b1) begin
            wr_t e;
            we_cnt++;
            check("s_ready_in_write", s_ready, 0);
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=no write", ins_addr, ins_wdata);
            end else begin
                e = wq.pop_front();
                check("write_addr", ins_addr, e.addr);
                check("write_data", ins_wdata, e.data);
            end
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("core_hold_at_done", core_hold, 0);
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load_done actual=1 required=0");
            end else begin
                check("checksum", checksum, cq.pop_front());
            end
        end
    end

    task automatic pulse_start(input int n);
        load_words = n[AW:0];
        load_start = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic stream(input int n, input int base, input bit rnd);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 20*n + 50) begin
            s_data  = 8'(base + got);
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                got++;
            end
            @(posedge clk); #1;
            budget++;
        end
        s_valid = 1'b0;
        check("bytes_accepted", got, n);
    endtask

    task automatic wait_done(input int prev, input int budget);
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("load_done_seen", done_cnt - prev, 1);
    endtask

    task automatic chk_reset();
        check("rst_s_ready", s_ready, 0);
        check("rst_ins_we", ins_we, 0);
        check("rst_ins_addr", ins_addr, 0);
        check("rst_ins_wdata", ins_wdata, 0);
        check("rst_core_hold", core_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_checksum", checksum, 0);
    endtask

    initial begin
        int d0;
        int w0;
        int extra;
        rst = 1'b1;
        load_start = 1'b0;
        load_words = '0;
        s_data = 8'h00;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();

        // Two words, s_valid held high.
        exp_wr(0, 64'h0706050403020100);
        exp_wr(1, 64'h0F0E0D0C0B0A0908);
        cq.push_back(64'h0808080808080808);
        d0 = done_cnt; w0 = we_cnt; first_acc_cyc = -1;
        pulse_start(2);
        stream(16, 8'h00, 1'b0);
        wait_done(d0, 50);
        check("done_latency", done_cyc - first_acc_cyc, 18);
        check("we_cycles_2w", we_cnt - w0, 2);
        check("core_hold_run", core_hold, 0);

        // Same load from RUN with random s_valid gaps.
        exp_wr(0, 64'h0706050403020100);
        exp_wr(1, 64'h0F0E0D0C0B0A0908);
        cq.push_back(64'h0808080808080808);
        d0 = done_cnt; w0 = we_cnt;
        pulse_start(2);
        check("core_hold_reload", core_hold, 1);
        stream(16, 8'h00, 1'b1);
        wait_done(d0, 50);
        check("we_cycles_rnd", we_cnt - w0, 2);

        // Reload of one word from RUN; a load_start during LOAD must be ignored.
        exp_wr(0, 64'h1716151413121110);
        cq.push_back(64'h1716151413121110);
        d0 = done_cnt;
        pulse_start(1);
        check("core_hold_after_start", core_hold, 1);
        check("busy_after_start", busy, 1);
        stream(4, 8'h10, 1'b0);
        pulse_start(5);
        check("busy_ignored_start", busy, 1);
        stream(4, 8'h14, 1'b0);
        wait_done(d0, 50);

        // Oversized request is clamped to the memory depth.
        for (int w = 0; w < 256; w++) exp_wr(w, mkword(8*w));
        cq.push_back(64'h0);
        d0 = done_cnt; w0 = we_cnt;
        pulse_start(300);
        stream(2048, 0, 1'b0);
        wait_done(d0, 50);
        check("we_cycles_clamp", we_cnt - w0, 256);
        extra = 0;
        s_data = 8'hEE;
        s_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (s_ready) extra++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("no_extra_accept", extra, 0);

        // Reset after 3 bytes of word 1 aborts the session.
        exp_wr(0, 64'h0706050403020100);
        pulse_start(2);
        stream(8, 8'h00, 1'b0);
        stream(3, 8'h08, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset();
        exp_wr(0, 64'hA7A6A5A4A3A2A1A0);
        cq.push_back(64'hA7A6A5A4A3A2A1A0);
        d0 = done_cnt;
        pulse_start(1);
        stream(8, 8'hA0, 1'b0);
        wait_done(d0, 50);

        // Empty load: straight to RUN with no writes.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cq.push_back(64'h0);
        d0 = done_cnt; w0 = we_cnt;
        pulse_start(0);
        wait_done(d0, 10);
        check("done_latency_empty", done_cyc - start_cyc, 1);
        check("we_cycles_empty", we_cnt - w0, 0);
        check("core_hold_empty", core_hold, 0);

        repeat (3) @(posedge clk);
        #1;
        check("writes_left", wq.size(), 0);
        check("dones_left", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Upstream stage of the instruction-memory/decoder pair. Fills instruction BRAM write port A, which is otherwise tied off.
- Accepts a byte stream from the host link (UART/JTAG bridge) over a valid/ready handshake and packs bytes little-endian into INS_WIDTH-bit instruction words.
- Writes each word to sequential instruction addresses starting at 0.
- Holds the decoder/PC in reset until loading completes, then releases the core to run.

Parameters:
INS_ADDR_WIDTH, 8, instruction memory address width (depth 2^INS_ADDR_WIDTH)
INS_WIDTH, 64, instruction word width; must be a multiple of 8
BYTES_PER_WORD, INS_WIDTH/8, bytes per instruction word (derived, not overridden)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, synchronous, active-high
load_start  input  1  one-cycle pulse; begins a load session
load_words  input  INS_ADDR_WIDTH+1  number of words to load; sampled on load_start
s_data  input  8  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts byte this cycle
ins_we  output  1  instruction BRAM port A write enable
ins_addr  output  INS_ADDR_WIDTH  port A address
ins_wdata  output  INS_WIDTH  port A write data
core_hold  output  1  high holds decoder/PC in reset
busy  output  1  high in LOAD or WRITE
load_done  output  1  one-cycle pulse when session completes
checksum  output  INS_WIDTH  XOR of all words written this session

Behaviour:
- Reset values: state=IDLE, s_ready=0, ins_we=0, ins_addr=0, ins_wdata=0, core_hold=1, busy=0, load_done=0, checksum=0; byte and word counters cleared.
- Reset has priority over all other inputs on the same edge and aborts any session in progress. BRAM contents already written are left untouched.
- States: IDLE, LOAD, WRITE, RUN.
- IDLE:
  - core_hold=1.
  - On load_start: latch len = min(load_words, 2^INS_ADDR_WIDTH), clear counters and checksum.
  - len==0: go to RUN and pulse load_done next cycle; no writes.
  - Otherwise go to LOAD.
- LOAD:
  - s_ready=1. A byte is accepted on an edge with s_valid&&s_ready.
  - Byte k (k=0..BYTES_PER_WORD-1) of a word goes to bits [8k+7:8k].
  - On acceptance of the last byte, go to WRITE.
- WRITE (exactly one cycle):
  - s_ready=0; ins_we=1, ins_addr=word_cnt, ins_wdata=assembled word.
  - On the edge leaving WRITE: checksum ^= word; word_cnt++.
  - If word_cnt+1==len: go to RUN with load_done=1 for the first RUN cycle. Otherwise return to LOAD.
- ins_we is high only in WRITE. ins_addr/ins_wdata hold their last values otherwise.
- RUN:
  - core_hold=0, s_ready=0.
  - load_start re-enters the IDLE load path on the same edge, so core_hold=1 from the next cycle. Re-programming is allowed.
- load_start is ignored while busy=1.
- s_valid is ignored when s_ready=0; bytes are never dropped or duplicated.
- Minimum throughput: BYTES_PER_WORD+1 cycles per word.
- Address never wraps: the len clamp guarantees word_cnt < 2^INS_ADDR_WIDTH.
- checksum is stable from load_done until the next load_start.

Test Plan:
- Reset then load_words=2, bytes 0x00..0x0F streamed with s_valid held high:
  - writes addr0=0x0706050403020100 and addr1=0x0F0E0D0C0B0A0908.
  - ins_we high exactly 2 cycles.
  - load_done pulses 18 cycles after the first accept.
  - checksum=0x0808080808080808; core_hold falls with load_done.
- Same load with s_valid toggled randomly (≈50%): identical writes and checksum; no byte lost. s_ready is low in every WRITE cycle.
- load_words=0: no ins_we; load_done one cycle after load_start; core_hold=0.
- load_words=300 with 256×8 bytes: writes addr 0..255 only, then RUN. Extra bytes are not accepted (s_ready=0).
- Assert rst mid-word (after 3 bytes of word 1):
  - all outputs return to reset values next cycle.
  - a subsequent load of 1 word starts at addr0 with a fresh byte order.
- In RUN, pulse load_start with load_words=1: core_hold=1 next cycle, the word is rewritten at addr0, and a second load_done pulse follows. A load_start during LOAD is ignored.
